sram_1p_req_ctrl: RTL and testbench
===================================

// Module: sram_1p_req_ctrl
// PURPOSE
//  Requester-side controller for a single-port SRAM array: turns a valid/ready request stream into
//  SRAM addr/wdata/wen cycles and returns read data on a valid/ready response stream.
//  Zero-fills the array after reset, then serves one request per cycle with a 2-entry response queue.
//  Sits between a cache/tag pipeline and the SRAM array macro.
// PARAMETERS
//  ADDR_W   6    SRAM address width
//  DATA_W   66   SRAM word width
//  DEPTH    64   number of entries (== 2**ADDR_W)
// PORTS
//  clock        in   1       single clock
//  reset        in   1       asynchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when valid&&ready
//  req_write    in   1       1=write, 0=read
//  req_addr     in   ADDR_W  entry index
//  req_wdata    in   DATA_W  write data
//  resp_valid   out  1       read data present
//  resp_ready   in   1       consumer takes response
//  resp_rdata   out  DATA_W  read data, in request order
//  sram_en      out  1       SRAM access this cycle
//  sram_wen     out  1       SRAM write this cycle
//  sram_addr    out  ADDR_W  SRAM address
//  sram_wdata   out  DATA_W  SRAM write data
//  sram_rdata   in   DATA_W  SRAM read data, valid the cycle after a read access
// BEHAVIOUR
//  - Reset values: req_ready=0, resp_valid=0, resp_rdata=0, sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
//  - FSM: INIT -> RUN. Reset forces INIT, init counter=0, response queue empty, pending-read flag clear.
//  - INIT: each cycle sram_en=1, sram_wen=1, sram_addr=counter, sram_wdata=0; counter++. After
//    addr DEPTH-1 is written, go to RUN next cycle. req_ready=0 throughout. Lasts exactly DEPTH cycles.
//  - RUN: sram_* are combinational from req_*: sram_en=req_valid&&req_ready, sram_wen=fire&&req_write.
//  - Write: completes in the accept cycle; no response; needs no queue space.
//  - Read: accepted at cycle T; sram_rdata sampled at T+1 and pushed into queue; resp_valid earliest T+2.
//  - Credits: occ = queue entries + pending read (0/1). A read needs occ<2, counting a pop this cycle.
//    req_ready = RUN && (req_write || occ - pop < 2). req_ready may depend on req_write; the
//    requester must not drop req_valid or change req_* until the handshake.
//  - Back-to-back reads sustain 1/cycle while resp_ready=1. Push and pop in the same cycle: occupancy unchanged.
//  - Queue full with resp_ready=0: reads stall and writes still proceed. Responses are never lost or reordered.
//  - Read after write to the same addr in consecutive cycles returns the new data (SRAM is read-after-write ordered).
//  - Reset mid-operation: pending read and queued responses are discarded and INIT restarts at addr 0.
// CONFIGURATION
//  SRAM_CTRL_INIT_EN defined: INIT sweep as above.
//  Not defined: INIT state is omitted, RUN is entered in the first cycle after reset deasserts, and
//    array contents are undefined.
// STRUCTURE
//  Package sram_ctrl_pkg: typedef enum {ST_INIT, ST_RUN} ctrl_state_t; localparams for ADDR_W, DATA_W,
//    DEPTH and RESP_DEPTH=2.
//  Sub-module resp_fifo2: 2-entry DATA_W FIFO (push/pop/full/empty/count), async active-high reset.
// TESTING
//  1. Reset, INIT_EN on: sram_wen=1 for exactly 64 cycles, addr 0..63, wdata 0 -> then req_ready=1.
//  2. Write addr 5 = 66'h2_DEAD_BEEF_0000_0001, then read addr 5 -> resp_rdata equals that value 2 cycles after accept.
//  3. resp_ready=1, 8 back-to-back reads of addrs 0..7 holding i -> 8 responses on consecutive cycles, data 0..7 in order.
//  4. resp_ready=0, issue 3 reads -> first 2 accepted, req_ready=0 on the 3rd; a write issued then is accepted.
//     Raise resp_ready -> 3rd read is accepted and all 3 responses are in order.
//  5. Assert reset during a read with 2 responses queued -> resp_valid=0 next cycle, INIT restarts at addr 0.
//  6. INIT_EN off: first post-reset cycle req_ready=1, and no sram_wen until the first write request.

Source files
------------

// File: rtl/sram_1p_req_ctrl_pkg.sv
// Shared types and sizing for the single-port SRAM requester controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_ctrl_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 66;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int RESP_DEPTH = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/sram_1p_req_ctrl_if.sv
// Request, response and SRAM-macro signals of the controller in one bundle.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
interface sram_1p_req_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    logic              sram_en;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Environment side: requester, response consumer and the SRAM macro itself.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, sram_rdata,
        input  req_ready, resp_valid, resp_rdata, sram_en, sram_wen, sram_addr, sram_wdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, sram_rdata,
        output req_ready, resp_valid, resp_rdata, sram_en, sram_wen, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_1p_req_ctrl_resp_fifo2.sv
// Two-entry response queue holding SRAM read data until the consumer takes it.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module resp_fifo2
    import sram_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [RESP_DEPTH];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; entries clear on reset so the head reads zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/sram_1p_req_ctrl.sv
// Single-port SRAM requester controller; optional zero-fill sweep under SRAM_CTRL_INIT_EN.
// Latency: write done in the accept cycle; read data on resp 2 cycles after accept.
// Backpressure: reads need a response credit (queue + in-flight < 2); writes never stall in RUN.
module sram_1p_req_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    sram_1p_req_ctrl_if.slave bus
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic              r_rd_pend;
    logic              w_fire;
    logic              w_pop;
    logic              w_rd_credit;
    logic [2:0]        w_occ;
    logic [1:0]        w_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_rdata;
`ifdef SRAM_CTRL_INIT_EN
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] w_init_cnt_nxt;
`endif

    resp_fifo2 u_resp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_rd_pend),
        .i_wdata (bus.sram_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.resp_valid = !w_empty;
    assign bus.resp_rdata = w_rdata;
    assign w_pop          = !w_empty && bus.resp_ready;
    // In-flight read counts against the queue; a pop this cycle frees a slot.
    assign w_occ          = {1'b0, w_count} + {2'b0, r_rd_pend};
    assign w_rd_credit    = w_occ < (3'd2 + {2'b0, w_pop});

    // Next state and all SRAM/request outputs; everything is held quiet while reset is high.
    always_comb begin
        w_state_nxt    = r_state;
        w_fire         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
`ifdef SRAM_CTRL_INIT_EN
        w_init_cnt_nxt = r_init_cnt;
`endif
        if (!i_rst) begin
            case (r_state)
                ST_INIT: begin
`ifdef SRAM_CTRL_INIT_EN
                    bus.sram_en    = 1'b1;
                    bus.sram_wen   = 1'b1;
                    bus.sram_addr  = r_init_cnt;
                    w_init_cnt_nxt = r_init_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = ST_RUN;
                    end
`else
                    w_state_nxt = ST_RUN;
`endif
                end
                ST_RUN: begin
                    bus.req_ready  = bus.req_write || w_rd_credit;
                    w_fire         = bus.req_valid && bus.req_ready;
                    bus.sram_en    = w_fire;
                    bus.sram_wen   = w_fire && bus.req_write;
                    bus.sram_addr  = bus.req_addr;
                    bus.sram_wdata = bus.req_wdata;
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    // State, sweep counter and the one-deep in-flight read flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
`ifdef SRAM_CTRL_INIT_EN
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
`else
            r_state    <= ST_RUN;
`endif
            r_rd_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
`ifdef SRAM_CTRL_INIT_EN
            r_init_cnt <= w_init_cnt_nxt;
`endif
            r_rd_pend  <= w_fire && !bus.req_write;
        end
    end

    // Read data returning from the SRAM always finds a free queue slot.
    always @(posedge i_clk) begin
        if (!i_rst && r_rd_pend) begin
            assert (!w_full || w_pop);
        end
    end

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Directed bench for sram_1p_req_ctrl with a queue scoreboard and an SRAM behavioural model.
// Latency: expected read responses carry their required cycle where it is deterministic.
// Backpressure: resp_ready is toggled to exercise read stalls and credit recovery.
module tb_sram_1p_req_ctrl;
    import sram_ctrl_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    int                cyc;
    int                checks;
    int                failures;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] r_sram_q;

    sram_1p_req_ctrl_if bus ();

    sram_1p_req_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number, counted on the active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM: write on the edge, read data the cycle after
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_wdata;
            else              r_sram_q <= mem[bus.sram_addr];
        end
    end
    assign bus.sram_rdata = r_sram_q;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every response taken is compared against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h required=none", bus.resp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", bus.resp_rdata, e.data);
                if (e.cyc >= 0) chk("resp_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
            end
        end
    end

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Present one request and hold it until accepted; reads queue their expected response
    task automatic do_req(input logic wr, input int addr, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp_d, input logic timed);
        bit done;
        exp_t e;
        done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_wdata = wr ? d : '0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                done = 1'b1;
                if (!wr) begin
                    e.data = exp_d;
                    e.cyc  = timed ? cyc + 2 : -1;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout actual=not_accepted required=accepted addr=%0d", addr);
            idle();
        end
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_req_ready",  DATA_W'(bus.req_ready),  '0);
        chk("rst_resp_valid", DATA_W'(bus.resp_valid), '0);
        chk("rst_resp_rdata", bus.resp_rdata,          '0);
        chk("rst_sram_en",    DATA_W'(bus.sram_en),    '0);
        chk("rst_sram_wen",   DATA_W'(bus.sram_wen),   '0);
        chk("rst_sram_addr",  DATA_W'(bus.sram_addr),  '0);
        chk("rst_sram_wdata", bus.sram_wdata,          '0);
    endtask

    // After reset release: zero-fill sweep (when built in) then the request side opens
    task automatic post_reset_check();
`ifdef SRAM_CTRL_INIT_EN
        int n;
        bit stop;
        n = 0;
        stop = 1'b0;
        for (int i = 0; i < 100 && !stop; i++) begin
            @(negedge clk);
            if (!bus.sram_wen) begin
                stop = 1'b1;
            end else begin
                chk("init_addr",  DATA_W'(bus.sram_addr), DATA_W'(n));
                chk("init_wdata", bus.sram_wdata, '0);
                chk("init_ready", DATA_W'(bus.req_ready), '0);
                n++;
            end
        end
        chk("init_len", DATA_W'(n), DATA_W'(64));
        chk("ready_after_init", DATA_W'(bus.req_ready), DATA_W'(1));
        @(posedge clk);
        #1;
`else
        @(negedge clk);
        chk("first_cycle_ready", DATA_W'(bus.req_ready), DATA_W'(1));
        for (int i = 0; i < 3; i++) begin
            chk("no_wen_before_write", DATA_W'(bus.sram_wen), '0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        chk(name, DATA_W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset_check();

        // Write then immediately read the same address
        do_req(1'b1, 5, 66'h2_DEAD_BEEF_0000_0001, '0, 1'b0);
        do_req(1'b0, 5, '0, 66'h2_DEAD_BEEF_0000_0001, 1'b1);
        idle();
        drain("drain_raw");

        // Fill 0..7, then stream reads back-to-back at full rate
        for (int i = 0; i < 8; i++) do_req(1'b1, i, DATA_W'(i), '0, 1'b0);
        for (int i = 0; i < 8; i++) do_req(1'b0, i, '0, DATA_W'(i), 1'b1);
        idle();
        drain("drain_stream");

        // Consumer stalls: third read must wait, a write still goes through
        bus.resp_ready = 1'b0;
        do_req(1'b0, 1, '0, DATA_W'(1), 1'b0);
        do_req(1'b0, 2, '0, DATA_W'(2), 1'b0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rd3_ready", DATA_W'(bus.req_ready), '0);
            @(posedge clk);
            #1;
        end
        bus.req_write = 1'b1;
        bus.req_addr  = ADDR_W'(20);
        bus.req_wdata = 66'h1_2345_6789_ABCD_EF01;
        @(negedge clk);
        chk("stall_write_ready", DATA_W'(bus.req_ready), DATA_W'(1));
        @(posedge clk);
        #1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(3);
        bus.req_wdata = '0;
        @(negedge clk);
        chk("stall_rd3_again", DATA_W'(bus.req_ready), '0);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        do_req(1'b0, 3, '0, DATA_W'(3), 1'b0);
        do_req(1'b0, 20, '0, 66'h1_2345_6789_ABCD_EF01, 1'b0);
        idle();
        drain("drain_stall");

        // Reset while responses are queued and a read is waiting
        bus.resp_ready = 1'b0;
        do_req(1'b0, 6, '0, DATA_W'(6), 1'b0);
        do_req(1'b0, 7, '0, DATA_W'(7), 1'b0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(4);
        @(negedge clk);
        chk("full_before_reset_vld", DATA_W'(bus.resp_valid), DATA_W'(1));
        chk("full_before_reset_rdy", DATA_W'(bus.req_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        idle();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_reset_resp_valid", DATA_W'(bus.resp_valid), '0);
        chk("mid_reset_sram_en", DATA_W'(bus.sram_en), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset_check();
`ifdef SRAM_CTRL_INIT_EN
        do_req(1'b0, 5, '0, '0, 1'b1);
        idle();
        drain("drain_zeroed");
`endif
        do_req(1'b1, 9, 66'h3_0000_0000_0000_00A5, '0, 1'b0);
        do_req(1'b0, 9, '0, 66'h3_0000_0000_0000_00A5, 1'b1);
        idle();
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
